// File: rtl/msu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msu_pkg
// Brief    : Shared types and constants for the MSU data-track fetch block.
// Revision : 1.0 - initial release
// ============================================================================
package msu_pkg;

   // log2 of the sector size in bytes
   localparam int c_sector_bits = 9;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      REQ   = 3'd2,
      FILL  = 3'd3,
      RD    = 3'd4,
      ACK   = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/msu_data_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : msu_data_fetch_if
// Brief    : Host request/response and storage sector-transfer signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface msu_data_fetch_if #(
   parameter int SECTOR_BITS = msu_pkg::c_sector_bits
);
   logic [31:0]            data_addr;
   logic                   data_seek;
   logic                   data_req;
   logic                   invalidate;
   logic [7:0]             data;
   logic                   data_ack;
   logic [31:0]            sd_lba;
   logic                   sd_rd;
   logic                   sd_ack;
   logic [SECTOR_BITS-1:0] sd_buff_addr;
   logic [7:0]             sd_buff_dout;
   logic                   sd_buff_wr;

   // slave: the fetch block; master: register block plus storage side
   modport slave (
      input  data_addr, data_seek, data_req, invalidate,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      output data, data_ack, sd_lba, sd_rd
   );

   modport master (
      output data_addr, data_seek, data_req, invalidate,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      input  data, data_ack, sd_lba, sd_rd
   );

endinterface
`default_nettype wire

// File: rtl/msu_sector_ram.sv
`default_nettype none
// ============================================================================
// Module   : msu_sector_ram
// Brief    : One-sector byte buffer, one write port, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module msu_sector_ram #(
   parameter int ADDR_BITS = 9
) (
   input  wire logic                 clk,
   input  wire logic                 i_wr_en,
   input  wire logic [ADDR_BITS-1:0] i_wr_addr,
   input  wire logic [7:0]           i_wr_data,
   input  wire logic                 i_rd_en,
   input  wire logic [ADDR_BITS-1:0] i_rd_addr,
   output      logic [7:0]           o_rd_data
);

   logic [7:0] r_mem [0:(1<<ADDR_BITS)-1];
   logic [7:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/msu_data_fetch.sv
`default_nettype none
// ============================================================================
// Module   : msu_data_fetch
// Brief    : Single-sector cached byte fetcher for the MSU data track.
// Revision : 1.0 - initial release
// ============================================================================
module msu_data_fetch
   import msu_pkg::*;
#(
   parameter int SECTOR_BITS = c_sector_bits
) (
   input wire logic         CLK,
   input wire logic         RST_N,
   msu_data_fetch_if.slave  bus
);

   localparam int c_tag_bits = 32 - SECTOR_BITS;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_seek_q;
   logic [31:0]             r_addr;
   logic [c_tag_bits-1:0]   r_tag;
   logic                    r_valid;
   logic                    r_pending;
   logic [7:0]              r_data;
   logic                    r_data_ack;
   logic                    r_sd_rd;
   logic [31:0]             r_sd_lba;

   logic                    w_event;
   logic                    w_start;
   logic                    w_hit;
   logic                    w_ram_wr;
   logic                    w_ram_rd;
   logic [7:0]              w_ram_dout;

   assign w_event  = (bus.data_seek & ~r_seek_q) | bus.data_req;
   assign w_start  = w_event | r_pending;
   assign w_hit    = r_valid && (r_addr[31:SECTOR_BITS] == r_tag);
   assign w_ram_wr = bus.sd_ack & bus.sd_buff_wr;
   assign w_ram_rd = (r_state == RD);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = CHECK;
         CHECK:   w_state_nxt = w_hit ? RD : REQ;
         REQ:     if (bus.sd_ack) w_state_nxt = FILL;
         FILL:    if (!bus.sd_ack) w_state_nxt = RD;
         RD:      w_state_nxt = ACK;
         ACK:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_seek_q   <= 1'b0;
         r_addr     <= '0;
         r_tag      <= '0;
         r_valid    <= 1'b0;
         r_pending  <= 1'b0;
         r_data     <= '0;
         r_data_ack <= 1'b0;
         r_sd_rd    <= 1'b0;
         r_sd_lba   <= '0;
      end else begin
         r_seek_q   <= bus.data_seek;
         r_data_ack <= (r_state == ACK);

         if (r_state == ACK) begin
            r_data <= w_ram_dout;
         end

         // Events arriving while busy collapse into one deferred fetch that
         // samples whatever data_addr is current when IDLE is reached.
         if (r_state == IDLE) begin
            r_pending <= 1'b0;
            if (w_start) begin
               r_addr <= bus.data_addr;
            end
         end else if (w_event) begin
            r_pending <= 1'b1;
         end

         if (r_state == CHECK && !w_hit) begin
            r_sd_lba <= {{SECTOR_BITS{1'b0}}, r_addr[31:SECTOR_BITS]};
            r_sd_rd  <= 1'b1;
         end else if (r_state == REQ && bus.sd_ack) begin
            r_sd_rd  <= 1'b0;
         end

         // A completing fill wins over a concurrent invalidate.
         if (r_state == FILL && !bus.sd_ack) begin
            r_tag   <= r_sd_lba[c_tag_bits-1:0];
            r_valid <= 1'b1;
         end else if (bus.invalidate || (r_state == CHECK && !w_hit)) begin
            r_valid <= 1'b0;
         end
      end
   end

   msu_sector_ram #(
      .ADDR_BITS (SECTOR_BITS)
   ) u_ram (
      .clk       (CLK),
      .i_wr_en   (w_ram_wr),
      .i_wr_addr (bus.sd_buff_addr),
      .i_wr_data (bus.sd_buff_dout),
      .i_rd_en   (w_ram_rd),
      .i_rd_addr (r_addr[SECTOR_BITS-1:0]),
      .o_rd_data (w_ram_dout)
   );

   assign bus.data     = r_data;
   assign bus.data_ack = r_data_ack;
   assign bus.sd_lba   = r_sd_lba;
   assign bus.sd_rd    = r_sd_rd;

endmodule
`default_nettype wire

// File: tb/tb_msu_data_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_msu_data_fetch
// Brief    : Scoreboard bench for msu_data_fetch with a simple storage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msu_data_fetch;

   localparam int SB = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   msu_data_fetch_if #(.SECTOR_BITS(SB)) bus ();

   msu_data_fetch #(.SECTOR_BITS(SB)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   int         total = 0;
   int         bad   = 0;
   int         fills = 0;
   logic       sd_rd_d = 1'b0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // storage content: byte i of sector s
   function automatic logic [7:0] pat(input logic [31:0] s, input int i);
      logic [7:0] sb;
      sb = {s[3:0], 4'h0};
      return 8'(i) ^ sb ^ 8'h82;
   endfunction

   // monitor: pops the scoreboard on each data_ack, checks data holds otherwise
   always @(negedge clk) begin
      if (bus.sd_rd && !sd_rd_d) fills++;
      sd_rd_d = bus.sd_rd;
      if (!rst_n) begin
         last_data = 8'h00;
      end else if (bus.data_ack) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got data 0x%0h, expected no ack", bus.data);
         end else begin
            check("data", {24'h0, bus.data}, {24'h0, exp_q.pop_front()});
         end
         last_data = bus.data;
      end else begin
         check("data_hold", {24'h0, bus.data}, {24'h0, last_data});
      end
   end

   task automatic pulse_req(input logic [31:0] a);
      @(negedge clk);
      bus.data_addr = a;
      bus.data_req  = 1'b1;
      @(negedge clk);
      bus.data_req  = 1'b0;
   endtask

   task automatic wait_ack(input string name);
      int n = 0;
      while (!bus.data_ack && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ack"}, {31'h0, bus.data_ack}, 32'd1);
      @(negedge clk);
      check({name, "_ack_pulse"}, {31'h0, bus.data_ack}, 32'd0);
   endtask

   // mode 0: plain fill; 1: three data_req pulses mid-fill; 2: reset mid-fill
   task automatic serve(input string name, input logic [31:0] lba, input int mode);
      int n = 0;
      while (!bus.sd_rd && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_sd_rd"}, {31'h0, bus.sd_rd}, 32'd1);
      check({name, "_lba"}, bus.sd_lba, lba);
      @(negedge clk);
      bus.sd_ack = 1'b1;
      @(negedge clk);
      check({name, "_rd_drop"}, {31'h0, bus.sd_rd}, 32'd0);
      for (int i = 0; i < 512; i++) begin
         bus.sd_buff_addr = 9'(i);
         bus.sd_buff_dout = pat(lba, i);
         bus.sd_buff_wr   = 1'b1;
         bus.data_req     = 1'b0;
         if (mode == 1 && (i == 10 || i == 20 || i == 30)) begin
            bus.data_addr = (i == 10) ? 32'h611 : (i == 20) ? 32'h622 : 32'h6F3;
            bus.data_req  = 1'b1;
         end
         if (mode == 2 && i == 40) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_sd_rd", {31'h0, bus.sd_rd}, 32'd0);
            check("rst_ack", {31'h0, bus.data_ack}, 32'd0);
            check("rst_lba", bus.sd_lba, 32'd0);
            check("rst_data", {24'h0, bus.data}, 32'd0);
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      bus.sd_buff_wr = 1'b0;
      bus.sd_ack     = 1'b0;
      bus.data_req   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f0;
      bus.data_addr    = '0;
      bus.data_seek    = 1'b0;
      bus.data_req     = 1'b0;
      bus.invalidate   = 1'b0;
      bus.sd_ack       = 1'b0;
      bus.sd_buff_addr = '0;
      bus.sd_buff_dout = '0;
      bus.sd_buff_wr   = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_data", {24'h0, bus.data}, 32'd0);
      check("reset_ack", {31'h0, bus.data_ack}, 32'd0);
      check("reset_sd_rd", {31'h0, bus.sd_rd}, 32'd0);
      check("reset_lba", bus.sd_lba, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // cold seek: 0x405 -> sector 2, byte 5
      exp_q.push_back(8'hA7);
      @(negedge clk);
      bus.data_addr = 32'h0000_0405;
      bus.data_seek = 1'b1;
      serve("cold", 32'd2, 0);
      wait_ack("cold");
      bus.data_seek = 1'b0;
      repeat (3) @(negedge clk);

      // hit in sector 2: ack exactly three edges after the sampling edge
      f0 = fills;
      exp_q.push_back(8'hA4);
      pulse_req(32'h406);
      @(negedge clk);
      check("hit_t1", {31'h0, bus.data_ack}, 32'd0);
      @(negedge clk);
      check("hit_t2", {31'h0, bus.data_ack}, 32'd0);
      @(negedge clk);
      check("hit_t3", {31'h0, bus.data_ack}, 32'd1);
      check("hit_sd_rd", {31'h0, bus.sd_rd}, 32'd0);
      @(negedge clk);
      check("hit_pulse", {31'h0, bus.data_ack}, 32'd0);
      check("hit_fills", fills - f0, 32'd0);
      repeat (2) @(negedge clk);

      // sector boundary crossing
      f0 = fills;
      exp_q.push_back(8'h6D);
      pulse_req(32'h3FF);
      serve("bnd1", 32'd1, 0);
      wait_ack("bnd1");
      exp_q.push_back(8'hA2);
      pulse_req(32'h400);
      serve("bnd2", 32'd2, 0);
      wait_ack("bnd2");
      check("bnd_fills", fills - f0, 32'd2);
      repeat (2) @(negedge clk);

      // coalescing: first ack from 0x600, one extra ack from final 0x6F3
      exp_q.push_back(8'hB2);
      exp_q.push_back(8'h41);
      pulse_req(32'h600);
      serve("coal", 32'd3, 1);
      wait_ack("coal1");
      wait_ack("coal2");
      repeat (10) @(negedge clk);

      // invalidate forces a miss in the cached sector
      @(negedge clk);
      bus.invalidate = 1'b1;
      @(negedge clk);
      bus.invalidate = 1'b0;
      exp_q.push_back(8'hB7);
      pulse_req(32'h605);
      serve("inv", 32'd3, 0);
      wait_ack("inv");
      repeat (2) @(negedge clk);

      // reset mid-fill, then the same sector must be fetched again
      pulse_req(32'hA10);
      serve("rstfill", 32'd5, 2);
      repeat (5) @(negedge clk);
      exp_q.push_back(8'hC2);
      pulse_req(32'hA10);
      serve("refetch", 32'd5, 0);
      wait_ack("refetch");

      repeat (10) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
